// File: rtl/sram_arbiter_pkg.sv
// Shared decoder constants: arbiter states, frame buffer base addresses and
// fixed requester slots on the external SRAM port.
package sram_arbiter_pkg;

    typedef enum logic {
        S_ARB_IDLE,
        S_ARB_OWN
    } arb_state_e;

    localparam logic [17:0] U_BASE_ADDRESS   = 18'd38400;
    localparam logic [17:0] V_BASE_ADDRESS   = 18'd57600;
    localparam logic [17:0] RGB_BASE_ADDRESS = 18'd146944;

    localparam int unsigned REQ_M1       = 0;
    localparam int unsigned REQ_M2_FETCH = 1;
    localparam int unsigned REQ_M2_WB    = 2;
    localparam int unsigned REQ_SPARE    = 3;

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Round-robin priority select: first requesting index at or after ptr,
// wrapping modulo NUM_REQ.
module sram_arbiter_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int j;

    // Walk from farthest to nearest so the closest requester wins last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= int'(NUM_REQ)) begin
                j = j - int'(NUM_REQ);
            end
            if (req[IDX_W'(j)]) begin
                idx   = IDX_W'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: round-robin ownership with capped bursts,
// registered SRAM side and fixed-latency tagged read return.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_BURST    = 64
) (
    input  logic                      CLOCK_50_I,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we_n,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        rdata_valid,
    input  logic [DATA_W-1:0]         SRAM_read_data,
    output logic [ADDR_W-1:0]         SRAM_address,
    output logic [DATA_W-1:0]         SRAM_write_data,
    output logic                      SRAM_we_n,
    output logic                      busy
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);
    localparam int unsigned PIPE_D = READ_LATENCY + 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic                   busy_q, busy_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   we_n_q, we_n_d;
    logic [PIPE_D-1:0]      pipe_vld_q, pipe_vld_d;
    logic [IDX_W-1:0]       pipe_idx_q [PIPE_D];
    logic [IDX_W-1:0]       pipe_idx_d [PIPE_D];
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [NUM_REQ-1:0]     rdata_valid_q, rdata_valid_d;

    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;
    logic                   own_req_c;
    logic                   own_we_n_c;
    logic [ADDR_W-1:0]      own_addr_c;
    logic [DATA_W-1:0]      own_wdata_c;
    logic                   others_c;
    logic                   beat_c;
    logic [IDX_W-1:0]       next_ptr_c;

    sram_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign own_req_c   = req[owner_q];
    assign own_we_n_c  = req_we_n[owner_q];
    assign own_addr_c  = req_addr[owner_q*ADDR_W +: ADDR_W];
    assign own_wdata_c = req_wdata[owner_q*DATA_W +: DATA_W];
    assign others_c    = |(req & ~(ONE << owner_q));
    assign beat_c      = (state_q == S_ARB_OWN) && own_req_c;
    assign next_ptr_c  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        gnt_d         = gnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_n_d        = 1'b1;
        pipe_vld_d    = pipe_vld_q;
        pipe_idx_d    = pipe_idx_q;
        rdata_d       = rdata_q;
        rdata_valid_d = '0;

        case (state_q)
            S_ARB_IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    owner_d = pick_idx;
                    gnt_d   = ONE << pick_idx;
                    cnt_d   = '0;
                    state_d = S_ARB_OWN;
                end
            end
            S_ARB_OWN: begin
                if (beat_c) begin
                    addr_d  = own_addr_c;
                    wdata_d = own_wdata_c;
                    we_n_d  = own_we_n_c;
                    if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        // Cap reached: yield only if someone else is waiting.
                        cnt_d = '0;
                        if (others_c) begin
                            gnt_d   = '0;
                            ptr_d   = next_ptr_c;
                            state_d = S_ARB_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    gnt_d   = '0;
                    ptr_d   = next_ptr_c;
                    cnt_d   = '0;
                    state_d = S_ARB_IDLE;
                end
            end
            default: state_d = S_ARB_IDLE;
        endcase

        busy_d = |gnt_d;

        // Read tag pipeline, aligned with SRAM data arrival.
        pipe_vld_d[0] = beat_c && own_we_n_c;
        pipe_idx_d[0] = owner_q;
        for (int i = 1; i < int'(PIPE_D); i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_idx_d[i] = pipe_idx_q[i-1];
        end

        if (pipe_vld_q[PIPE_D-1]) begin
            rdata_d       = SRAM_read_data;
            rdata_valid_d = ONE << pipe_idx_q[PIPE_D-1];
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            state_q       <= S_ARB_IDLE;
            owner_q       <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            busy_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_n_q        <= 1'b1;
            pipe_vld_q    <= '0;
            for (int i = 0; i < int'(PIPE_D); i++) begin
                pipe_idx_q[i] <= '0;
            end
            rdata_q       <= '0;
            rdata_valid_q <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            busy_q        <= busy_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_n_q        <= we_n_d;
            pipe_vld_q    <= pipe_vld_d;
            pipe_idx_q    <= pipe_idx_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign gnt             = gnt_q;
    assign busy            = busy_q;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wdata_q;
    assign SRAM_we_n       = we_n_q;
    assign rdata           = rdata_q;
    assign rdata_valid     = rdata_valid_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter; SRAM model returns addr ^ 0xA5A5 two
// cycles after the registered address.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  req_we_n = '1;
    logic [71:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [3:0]  gnt;
    logic [15:0] rdata;
    logic [3:0]  rdata_valid;
    logic [15:0] SRAM_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        busy;

    logic [17:0] a1 = '0;
    logic [17:0] a2 = '0;

    int n_vec = 0;
    int n_err = 0;

    sram_arbiter #(
        .NUM_REQ(4), .ADDR_W(18), .DATA_W(16), .READ_LATENCY(2), .MAX_BURST(4)
    ) dut (
        .CLOCK_50_I      (clk),
        .reset           (reset),
        .req             (req),
        .req_we_n        (req_we_n),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .gnt             (gnt),
        .rdata           (rdata),
        .rdata_valid     (rdata_valid),
        .SRAM_read_data  (SRAM_read_data),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .busy            (busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        a1 <= SRAM_address;
        a2 <= a1;
    end
    assign SRAM_read_data = a2[15:0] ^ 16'hA5A5;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input logic r, input logic wn,
                          input logic [17:0] a, input logic [15:0] d);
        req[i]               = r;
        req_we_n[i]          = wn;
        req_addr[i*18 +: 18] = a;
        req_wdata[i*16 +: 16] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        n_vec++;
        if ({gnt, busy, rdata_valid} !== 9'b0) begin
            n_err++; $display("FAIL reset_ctl: got gnt=%b busy=%b rv=%b want 0", gnt, busy, rdata_valid);
        end
        n_vec++;
        if ({SRAM_address, SRAM_write_data, SRAM_we_n, rdata} !== {18'd0, 16'd0, 1'b1, 16'd0}) begin
            n_err++; $display("FAIL reset_sram: got a=%h wd=%h we_n=%b rd=%h", SRAM_address, SRAM_write_data, SRAM_we_n, rdata);
        end
    endtask

    task automatic test_single_read();
        logic [15:0] exp_rd [3];
        exp_rd[0] = 16'hA5B5; exp_rd[1] = 16'hA5B4; exp_rd[2] = 16'hA5B7;
        set_in(0, 1'b1, 1'b1, 18'h00010, 16'h0);
        cyc(); // c1
        n_vec++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            n_err++; $display("FAIL single_gnt: got gnt=%b busy=%b want 0001/1", gnt, busy);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(); // c2..c4
            n_vec++;
            if (SRAM_address !== 18'h00010 + 18'(k) || SRAM_we_n !== 1'b1) begin
                n_err++; $display("FAIL single_addr%0d: got %h we_n=%b want %h", k, SRAM_address, SRAM_we_n, 18'h00010 + 18'(k));
            end
            if (k < 2) set_in(0, 1'b1, 1'b1, 18'h00011 + 18'(k), 16'h0);
            else       set_in(0, 1'b0, 1'b1, 18'h00012, 16'h0);
        end
        n_vec++;
        if (rdata_valid !== 4'b0000) begin
            n_err++; $display("FAIL single_early: got rv=%b want 0000", rdata_valid);
        end
        cyc(); // c5
        n_vec++;
        if (gnt !== 4'b0000 || SRAM_we_n !== 1'b1) begin
            n_err++; $display("FAIL single_release: got gnt=%b we_n=%b want 0000/1", gnt, SRAM_we_n);
        end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (rdata_valid !== 4'b0001 || rdata !== exp_rd[k]) begin
                n_err++; $display("FAIL single_rdata%0d: got rv=%b rd=%h want 0001 %h", k, rdata_valid, rdata, exp_rd[k]);
            end
            cyc(); // c6..c8
        end
        n_vec++;
        if (rdata_valid !== 4'b0000) begin
            n_err++; $display("FAIL single_tail: got rv=%b want 0000", rdata_valid);
        end
    endtask

    task automatic test_contention();
        do_reset();
        set_in(1, 1'b1, 1'b1, 18'h00100, 16'h0);
        set_in(3, 1'b1, 1'b1, 18'h00300, 16'h0);
        cyc(); // c1
        n_vec++;
        if (gnt !== 4'b0010) begin
            n_err++; $display("FAIL cont_first: got gnt=%b want 0010", gnt);
        end
        cyc(); // c2
        n_vec++;
        if (SRAM_address !== 18'h00100) begin
            n_err++; $display("FAIL cont_addr1: got %h want 00100", SRAM_address);
        end
        set_in(1, 1'b0, 1'b1, 18'h00100, 16'h0);
        cyc(); // c3
        n_vec++;
        if (gnt !== 4'b0000 || SRAM_we_n !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL cont_gap: got gnt=%b we_n=%b busy=%b want 0000/1/0", gnt, SRAM_we_n, busy);
        end
        cyc(); // c4
        n_vec++;
        if (gnt !== 4'b1000) begin
            n_err++; $display("FAIL cont_second: got gnt=%b want 1000", gnt);
        end
        cyc(); // c5
        n_vec++;
        if (SRAM_address !== 18'h00300 || rdata_valid !== 4'b0010 || rdata !== 16'hA4A5) begin
            n_err++; $display("FAIL cont_ret1: got a=%h rv=%b rd=%h want 00300 0010 a4a5", SRAM_address, rdata_valid, rdata);
        end
        set_in(1, 1'b1, 1'b1, 18'h00101, 16'h0);
        set_in(3, 1'b0, 1'b1, 18'h00300, 16'h0);
        cyc(); // c6
        n_vec++;
        if (gnt !== 4'b0000) begin
            n_err++; $display("FAIL cont_gap2: got gnt=%b want 0000", gnt);
        end
        cyc(); // c7
        n_vec++;
        if (gnt !== 4'b0010) begin
            n_err++; $display("FAIL cont_wrap: got gnt=%b want 0010", gnt);
        end
        cyc(); // c8
        n_vec++;
        if (rdata_valid !== 4'b1000 || rdata !== 16'hA6A5) begin
            n_err++; $display("FAIL cont_ret3: got rv=%b rd=%h want 1000 a6a5", rdata_valid, rdata);
        end
        set_in(1, 1'b0, 1'b1, 18'h00101, 16'h0);
        cyc(); cyc(); cyc(); // c11
        n_vec++;
        if (rdata_valid !== 4'b0010 || rdata !== 16'hA4A4) begin
            n_err++; $display("FAIL cont_ret1b: got rv=%b rd=%h want 0010 a4a4", rdata_valid, rdata);
        end
        cyc();
    endtask

    task automatic test_burst_cap();
        do_reset();
        set_in(0, 1'b1, 1'b0, 18'h3E000, 16'h1000);
        set_in(2, 1'b1, 1'b0, 18'h2AAAA, 16'hBEEF);
        cyc(); // c1
        n_vec++;
        if (gnt !== 4'b0001) begin
            n_err++; $display("FAIL burst_gnt: got gnt=%b want 0001", gnt);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(); // c2..c5
            n_vec++;
            if (SRAM_address !== 18'h3E000 + 18'(k) || SRAM_we_n !== 1'b0 ||
                SRAM_write_data !== 16'h1000 + 16'(k) || gnt !== ((k < 3) ? 4'b0001 : 4'b0000)) begin
                n_err++; $display("FAIL burst_beat%0d: got a=%h we_n=%b wd=%h gnt=%b", k, SRAM_address, SRAM_we_n, SRAM_write_data, gnt);
            end
            set_in(0, 1'b1, 1'b0, 18'h3E001 + 18'(k), 16'h1001 + 16'(k));
        end
        cyc(); // c6
        n_vec++;
        if (SRAM_we_n !== 1'b1 || gnt !== 4'b0100 || rdata_valid !== 4'b0000) begin
            n_err++; $display("FAIL burst_switch: got we_n=%b gnt=%b rv=%b want 1 0100 0000", SRAM_we_n, gnt, rdata_valid);
        end
        cyc(); // c7
        n_vec++;
        if (SRAM_address !== 18'h2AAAA || SRAM_we_n !== 1'b0 || SRAM_write_data !== 16'hBEEF) begin
            n_err++; $display("FAIL burst_req2: got a=%h we_n=%b wd=%h want 2aaaa 0 beef", SRAM_address, SRAM_we_n, SRAM_write_data);
        end
        set_in(2, 1'b0, 1'b0, 18'h2AAAA, 16'hBEEF);
        cyc(); // c8
        n_vec++;
        if (gnt !== 4'b0000 || SRAM_we_n !== 1'b1) begin
            n_err++; $display("FAIL burst_gap: got gnt=%b we_n=%b want 0000/1", gnt, SRAM_we_n);
        end
        cyc(); // c9
        n_vec++;
        if (gnt !== 4'b0001) begin
            n_err++; $display("FAIL burst_resume_gnt: got gnt=%b want 0001", gnt);
        end
        cyc(); // c10
        n_vec++;
        if (SRAM_address !== 18'h3E004 || SRAM_write_data !== 16'h1004 || SRAM_we_n !== 1'b0) begin
            n_err++; $display("FAIL burst_resume: got a=%h wd=%h we_n=%b want 3e004 1004 0", SRAM_address, SRAM_write_data, SRAM_we_n);
        end
        set_in(0, 1'b0, 1'b1, 18'h3E004, 16'h1004);
        cyc(); // c11
        n_vec++;
        if (SRAM_we_n !== 1'b1 || gnt !== 4'b0000 || rdata_valid !== 4'b0000) begin
            n_err++; $display("FAIL burst_end: got we_n=%b gnt=%b rv=%b want 1 0000 0000", SRAM_we_n, gnt, rdata_valid);
        end
    endtask

    task automatic test_read_across_switch();
        do_reset();
        set_in(0, 1'b1, 1'b1, 18'h00020, 16'h0);
        cyc(); // c1
        n_vec++;
        if (gnt !== 4'b0001) begin
            n_err++; $display("FAIL xsw_gnt0: got gnt=%b want 0001", gnt);
        end
        cyc(); // c2
        n_vec++;
        if (SRAM_address !== 18'h00020 || SRAM_we_n !== 1'b1) begin
            n_err++; $display("FAIL xsw_addr: got a=%h we_n=%b want 00020/1", SRAM_address, SRAM_we_n);
        end
        set_in(0, 1'b0, 1'b1, 18'h00020, 16'h0);
        set_in(1, 1'b1, 1'b0, 18'h00040, 16'h5555);
        cyc(); // c3
        cyc(); // c4
        n_vec++;
        if (gnt !== 4'b0010 || SRAM_we_n !== 1'b1) begin
            n_err++; $display("FAIL xsw_gnt1: got gnt=%b we_n=%b want 0010/1", gnt, SRAM_we_n);
        end
        cyc(); // c5
        n_vec++;
        if (SRAM_address !== 18'h00040 || SRAM_we_n !== 1'b0 || SRAM_write_data !== 16'h5555) begin
            n_err++; $display("FAIL xsw_write: got a=%h we_n=%b wd=%h want 00040 0 5555", SRAM_address, SRAM_we_n, SRAM_write_data);
        end
        n_vec++;
        if (rdata_valid !== 4'b0001 || rdata !== 16'hA585) begin
            n_err++; $display("FAIL xsw_ret: got rv=%b rd=%h want 0001 a585", rdata_valid, rdata);
        end
        set_in(1, 1'b0, 1'b1, 18'h00040, 16'h5555);
        cyc(); // c6
        n_vec++;
        if (SRAM_we_n !== 1'b1 || rdata_valid !== 4'b0000) begin
            n_err++; $display("FAIL xsw_after: got we_n=%b rv=%b want 1 0000", SRAM_we_n, rdata_valid);
        end
    endtask

    task automatic test_reset_mid_read();
        set_in(2, 1'b1, 1'b1, 18'h00030, 16'h0);
        cyc(); // c1
        n_vec++;
        if (gnt !== 4'b0100) begin
            n_err++; $display("FAIL rst_gnt2: got gnt=%b want 0100", gnt);
        end
        cyc(); // c2
        cyc(); // c3
        reset = 1'b1;
        set_in(2, 1'b0, 1'b1, 18'h00030, 16'h0);
        cyc(); // c4
        reset = 1'b0;
        n_vec++;
        if ({gnt, busy, rdata_valid, SRAM_address, SRAM_write_data, SRAM_we_n, rdata} !==
            {4'b0, 1'b0, 4'b0, 18'd0, 16'd0, 1'b1, 16'd0}) begin
            n_err++; $display("FAIL rst_outputs: got gnt=%b busy=%b rv=%b a=%h wd=%h we_n=%b rd=%h",
                              gnt, busy, rdata_valid, SRAM_address, SRAM_write_data, SRAM_we_n, rdata);
        end
        set_in(1, 1'b1, 1'b1, 18'h00001, 16'h0);
        set_in(3, 1'b1, 1'b1, 18'h00003, 16'h0);
        cyc(); // c5
        n_vec++;
        if (gnt !== 4'b0010 || rdata_valid !== 4'b0000) begin
            n_err++; $display("FAIL rst_ptr: got gnt=%b rv=%b want 0010 0000", gnt, rdata_valid);
        end
        set_in(1, 1'b0, 1'b1, 18'h00001, 16'h0);
        set_in(3, 1'b0, 1'b1, 18'h00003, 16'h0);
        for (int k = 0; k < 2; k++) begin
            cyc(); // c6, c7
            n_vec++;
            if (rdata_valid !== 4'b0000) begin
                n_err++; $display("FAIL rst_no_ret%0d: got rv=%b want 0000", k, rdata_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_burst_cap();
        test_read_across_switch();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
